// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - fetch handshake and control-unit drive bundle
interface instr_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int IR_W   = 9
);
  logic              oMemReq;
  logic [ADDR_W-1:0] oMemAddr;
  logic              iMemAck;
  logic [IR_W-1:0]   iMemData;
  logic              oRun;
  logic [IR_W-1:0]   oIr;
  logic [1:0]        oState;
  logic              iDone;

  modport master (
    output oMemReq, oMemAddr, oRun, oIr, oState,
    input  iMemAck, iMemData, iDone
  );

  modport slave (
    input  oMemReq, oMemAddr, oRun, oIr, oState,
    output iMemAck, iMemData, iDone
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches instruction words and steps the control unit through T0..T3
module instr_sequencer #(
  parameter int ADDR_W = 8,
  parameter int IR_W   = 9,
  parameter int CNT_W  = 16
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iStart,
  input  logic [ADDR_W-1:0]   iStartAddr,
  input  logic                iHalt,
  input  logic                iStepMode,
  instr_sequencer_if.master   bus,
  output logic [ADDR_W-1:0]   oPc,
  output logic                oBusy,
  output logic                oErr,
  output logic [CNT_W-1:0]    oInstrCnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [1:0]        r_step;
  logic              r_halt;
  logic              r_err;
  logic              r_req;
  logic              r_run;
  logic [CNT_W-1:0]  r_cnt;

  // A halt arriving in the retiring cycle itself must still stop the sequencer.
  wire w_stop_after = r_halt | iHalt | iStepMode;
  wire w_cnt_max    = &r_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_step  <= 2'd0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_run   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (iStart) begin
            r_pc    <= iStartAddr;
            r_err   <= 1'b0;
            r_halt  <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (iHalt) r_halt <= 1'b1;
          if (bus.iMemAck) begin
            r_ir    <= bus.iMemData;
            r_pc    <= r_pc + ADDR_W'(1);
            r_step  <= 2'd0;
            r_req   <= 1'b0;
            r_run   <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.iDone) begin
            if (!w_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
            r_step <= 2'd0;
            r_run  <= 1'b0;
            if (w_stop_after) begin
              r_halt  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          end else if (r_step == 2'd3) begin
            r_step  <= 2'd0;
            r_run   <= 1'b0;
            r_err   <= 1'b1;
            r_halt  <= 1'b0;
            r_state <= S_ERROR;
          end else begin
            r_step <= r_step + 2'd1;
            if (iHalt) r_halt <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_step is forced to zero whenever EXEC is left, so it can drive oState directly.
  assign bus.oMemReq  = r_req;
  assign bus.oMemAddr = r_pc;
  assign bus.oRun     = r_run;
  assign bus.oIr      = r_ir;
  assign bus.oState   = r_step;
  assign oPc          = r_pc;
  assign oBusy        = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign oErr         = r_err;
  assign oInstrCnt    = r_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed and randomized checks of instr_sequencer against a cycle model
module tb_instr_sequencer;
  localparam int ADDR_W = 8;
  localparam int IR_W   = 9;
  localparam int CNT_W  = 16;
  localparam int CNT_S  = 4;
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_ERR = 3;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic iStart = 1'b0;
  logic [ADDR_W-1:0] iStartAddr = '0;
  logic iHalt = 1'b0;
  logic iStepMode = 1'b0;
  logic [ADDR_W-1:0] oPc, s_pc;
  logic oBusy, oErr, s_busy, s_err;
  logic [CNT_W-1:0] oInstrCnt;
  logic [CNT_S-1:0] s_cnt;

  always #5 iClk = ~iClk;

  instr_sequencer_if #(.ADDR_W(ADDR_W), .IR_W(IR_W)) bus ();
  instr_sequencer_if #(.ADDR_W(ADDR_W), .IR_W(IR_W)) bus_s ();
  assign bus_s.iMemAck  = bus.iMemAck;
  assign bus_s.iMemData = bus.iMemData;
  assign bus_s.iDone    = bus.iDone;

  instr_sequencer #(.ADDR_W(ADDR_W), .IR_W(IR_W), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStartAddr(iStartAddr),
    .iHalt(iHalt), .iStepMode(iStepMode), .bus(bus),
    .oPc(oPc), .oBusy(oBusy), .oErr(oErr), .oInstrCnt(oInstrCnt)
  );

  instr_sequencer #(.ADDR_W(ADDR_W), .IR_W(IR_W), .CNT_W(CNT_S)) dut_s (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStartAddr(iStartAddr),
    .iHalt(iHalt), .iStepMode(iStepMode), .bus(bus_s),
    .oPc(s_pc), .oBusy(s_busy), .oErr(s_err), .oInstrCnt(s_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the sequencer should be doing, tracked per instruction.
  int m_mode = M_IDLE;
  int m_t = 0;
  int m_retired = 0;
  logic [ADDR_W-1:0] m_pc = '0;
  logic [IR_W-1:0] m_ir = '0;
  bit m_err = 0;
  bit m_halt = 0;

  logic [IR_W-1:0] mem [256];
  bit rnd_mode = 0;
  int mem_wait = 0;
  int done_at = 1;
  int fwait = 0;
  int cyc = 0;
  int last_rise = 0;
  int period = 0;
  bit last_req = 0;
  int base_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_t = 0; m_retired = 0; m_pc = '0; m_ir = '0;
    m_err = 0; m_halt = 0; fwait = 0;
  endtask

  task automatic model_edge();
    case (m_mode)
      M_IDLE, M_ERR: begin
        if (iStart) begin
          m_pc = iStartAddr; m_err = 0; m_halt = 0; m_mode = M_FETCH;
        end
      end
      M_FETCH: begin
        if (iHalt) m_halt = 1;
        if (bus.iMemAck) begin
          m_ir = bus.iMemData; m_pc = m_pc + 8'd1; m_t = 0; m_mode = M_EXEC;
        end
      end
      M_EXEC: begin
        if (iHalt) m_halt = 1;
        if (bus.iDone) begin
          m_retired++;
          m_t = 0;
          if (m_halt || iStepMode) begin
            m_mode = M_IDLE; m_halt = 0;
          end else m_mode = M_FETCH;
        end else if (m_t == 3) begin
          m_mode = M_ERR; m_err = 1; m_halt = 0; m_t = 0;
        end else m_t++;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    int exp_cnt, exp_s;
    exp_cnt = (m_retired > 65535) ? 65535 : m_retired;
    exp_s   = (m_retired > 15) ? 15 : m_retired;
    chk("memreq", 32'(bus.oMemReq), 32'(m_mode == M_FETCH));
    if (m_mode == M_FETCH) chk("memaddr", 32'(bus.oMemAddr), 32'(m_pc));
    chk("run", 32'(bus.oRun), 32'(m_mode == M_EXEC));
    chk("ir", 32'(bus.oIr), 32'(m_ir));
    chk("state", 32'(bus.oState), (m_mode == M_EXEC) ? 32'(m_t) : 32'd0);
    chk("pc", 32'(oPc), 32'(m_pc));
    chk("busy", 32'(oBusy), 32'(m_mode == M_FETCH || m_mode == M_EXEC));
    chk("err", 32'(oErr), 32'(m_err));
    chk("cnt", 32'(oInstrCnt), 32'(exp_cnt));
    chk("cnt_small", 32'(s_cnt), 32'(exp_s));
  endtask

  task automatic cycle();
    int prev;
    bus.iMemData = mem[m_pc];
    if (rnd_mode) begin
      bus.iMemAck = ($urandom_range(0, 2) == 0);
      bus.iDone   = ($urandom_range(0, 3) == 0);
    end else begin
      bus.iMemAck = (m_mode == M_FETCH) && (fwait >= mem_wait);
      bus.iDone   = (m_mode == M_EXEC) && (m_t == done_at);
    end
    prev = m_mode;
    model_edge();
    if (m_mode == M_FETCH) fwait = (prev == M_FETCH) ? fwait + 1 : 0;
    @(posedge iClk);
    #1;
    cyc++;
    if (bus.oMemReq && !last_req) begin
      period = cyc - last_rise;
      last_rise = cyc;
    end
    last_req = bus.oMemReq;
    check_all();
    iStart = 1'b0;
    iHalt = 1'b0;
  endtask

  task automatic run_until_stopped(input int max);
    int i;
    for (i = 0; i < max && (m_mode == M_FETCH || m_mode == M_EXEC); i++) cycle();
    if (m_mode == M_FETCH || m_mode == M_EXEC) begin
      n_vec++; n_err++;
      $error("FAIL timeout waiting for stop after %0d cycles", max);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = IR_W'($urandom);
    bus.iMemAck = 1'b0;
    bus.iMemData = '0;
    bus.iDone = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_memreq", 32'(bus.oMemReq), 32'd0);
    chk("rst_memaddr", 32'(bus.oMemAddr), 32'd0);
    check_all();
    iRst_n = 1'b1;

    // mv at 0x10, zero-wait memory, done at T1
    for (int i = 8'h10; i < 8'h20; i++) mem[i] = 9'b000_001_010;
    mem_wait = 0; done_at = 1;
    iStartAddr = 8'h10; iStart = 1'b1;
    cycle();
    chk("t1_addr", 32'(bus.oMemAddr), 32'h10);
    cycle();
    chk("t1_ir", 32'(bus.oIr), 32'h00A);
    chk("t1_t0", 32'(bus.oState), 32'd0);
    cycle();
    chk("t1_t1", 32'(bus.oState), 32'd1);
    cycle();
    chk("t1_cnt", 32'(oInstrCnt), 32'd1);
    chk("t1_pc", 32'(oPc), 32'h11);
    chk("t1_next_addr", 32'(bus.oMemAddr), 32'h11);
    repeat (9) cycle();
    chk("mv_period", 32'(period), 32'd3);
    iHalt = 1'b1;
    run_until_stopped(20);

    // add with 2 extra wait cycles, done only at T3
    for (int i = 8'h20; i < 8'h30; i++) mem[i] = 9'b010_000_001;
    mem_wait = 2; done_at = 3;
    iStartAddr = 8'h20; iStart = 1'b1;
    repeat (22) cycle();
    chk("add_period", 32'(period), 32'd7);
    iHalt = 1'b1;
    run_until_stopped(20);

    // done never arrives: step timeout, then restart clears the error
    base_cnt = m_retired;
    mem_wait = 0; done_at = 4;
    iStartAddr = 8'h30; iStart = 1'b1;
    repeat (6) cycle();
    chk("to_err", 32'(oErr), 32'd1);
    chk("to_run", 32'(bus.oRun), 32'd0);
    chk("to_cnt", 32'(oInstrCnt), 32'(base_cnt));
    done_at = 1;
    iStartAddr = 8'h38; iStart = 1'b1;
    cycle();
    chk("restart_err", 32'(oErr), 32'd0);
    chk("restart_addr", 32'(bus.oMemAddr), 32'h38);
    iHalt = 1'b1;
    run_until_stopped(20);

    // single-step mode, with an ignored start while executing
    iStepMode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iStartAddr = 8'(8'h40 + k); iStart = 1'b1;
      cycle();
      cycle();
      iStartAddr = 8'h99; iStart = 1'b1;
      cycle();
      run_until_stopped(10);
      chk("step_busy", 32'(oBusy), 32'd0);
      chk("step_pc", 32'(oPc), 32'(8'h41 + k));
    end
    iStepMode = 1'b0;

    // halt during a delayed fetch at 0xFF: executes, then wraps PC to 0
    mem_wait = 2; done_at = 2;
    iStartAddr = 8'hFF; iStart = 1'b1;
    cycle();
    iHalt = 1'b1;
    cycle();
    run_until_stopped(20);
    chk("wrap_pc", 32'(oPc), 32'd0);
    chk("wrap_busy", 32'(oBusy), 32'd0);

    // randomized traffic, including acks/dones outside their phases
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      iStart = ($urandom_range(0, 19) == 0);
      iStartAddr = ADDR_W'($urandom);
      iHalt = ($urandom_range(0, 24) == 0);
      if (i % 200 == 0) iStepMode = 1'($urandom_range(0, 1));
      cycle();
    end
    rnd_mode = 0; iStepMode = 1'b0;
    mem_wait = 0; done_at = 0;
    iHalt = 1'b1;
    run_until_stopped(20);

    // saturate the narrow counter, then reset mid-EXEC at T2
    iStartAddr = ADDR_W'($urandom); iStart = 1'b1;
    repeat (40) cycle();
    chk("sat_small", 32'(s_cnt), 32'hF);
    done_at = 4;
    for (int i = 0; i < 10 && !(m_mode == M_EXEC && m_t == 2); i++) cycle();
    chk("pre_rst_t2", 32'(bus.oState), 32'd2);
    iRst_n = 1'b0;
    #2;
    model_reset();
    chk("arst_memreq", 32'(bus.oMemReq), 32'd0);
    chk("arst_memaddr", 32'(bus.oMemAddr), 32'd0);
    chk("arst_run", 32'(bus.oRun), 32'd0);
    chk("arst_state", 32'(bus.oState), 32'd0);
    chk("arst_ir", 32'(bus.oIr), 32'd0);
    chk("arst_pc", 32'(oPc), 32'd0);
    chk("arst_busy", 32'(oBusy), 32'd0);
    chk("arst_err", 32'(oErr), 32'd0);
    chk("arst_cnt", 32'(oInstrCnt), 32'd0);
    chk("arst_cnt_small", 32'(s_cnt), 32'd0);
    chk("arst_small_busy", 32'(s_busy), 32'd0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    done_at = 1;
    iStartAddr = 8'h50; iStart = 1'b1;
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
